add_sub: RTL and testbench
==========================

ADD_SUB -- requirements
Module: add_sub

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operands and OP are sampled on a rising edge where in_valid=1.
REQ-005 OP  input  1  operation select: 0 = add (A+B), 1 = subtract (A-B).
REQ-006 A  input  3  sign-magnitude operand: A[2] is the sign (1 = negative) and A[1:0] is the magnitude, range -3..+3.
REQ-007 B  input  3  sign-magnitude operand with the same encoding as A.
REQ-008 R  output  4  registered sign-magnitude result: R[3] is the sign and R[2:0] is the magnitude, range -6..+6.
REQ-009 SF  output  1  registered sign flag; equals R[3].
REQ-010 ZF  output  1  registered zero flag; 1 when R == 4'b0000.
REQ-011 DZF  output  1  divide-by-zero flag, present for ALU flag compatibility; always 0 in this block.
REQ-012 out_valid  output  1  1 for exactly the cycle after an accepted operation.

Function
REQ-013 Effective B sign: sb = B[2] XOR OP; the magnitudes are ma = A[1:0] and mb = B[1:0].
REQ-014 If A[2] == sb, the result magnitude SHALL be ma+mb (3 bits, no overflow possible) and the result sign SHALL be A[2].
REQ-015 If A[2] != sb and ma > mb, the result SHALL be magnitude ma-mb with sign A[2].
REQ-016 If A[2] != sb and mb > ma, the result SHALL be magnitude mb-ma with sign sb.
REQ-017 Any zero-magnitude result SHALL be encoded as 4'b0000, so SF=0 and ZF=1; negative zero is never output.
REQ-018 When ADD_SUB_INVZ_EN is not defined, an input encoding of 3'b100 (negative zero) SHALL be treated as +0.
REQ-019 Latency is 1 cycle: the result for operands sampled at edge N appears on R/SF/ZF at edge N and out_valid is 1 until edge N+1.
REQ-020 When in_valid=0, R, SF, ZF and DZF SHALL hold their values and out_valid SHALL be 0 on the next edge.
REQ-021 Back-to-back operations with in_valid=1 on every cycle SHALL each produce a result; there is no backpressure.

Reset
REQ-022 On a rising edge with rst_n=0, R SHALL be 0000, SF 0, ZF 1, DZF 0, out_valid 0 (and INVZ 0 when present).
REQ-023 Reset SHALL take priority over in_valid; an operation presented during reset is discarded.

Configuration
REQ-024 Macro ADD_SUB_INVZ_EN: when defined, the block SHALL add a registered output INVZ (1 bit).
REQ-025 INVZ SHALL be 1 with the result when A or B equals 3'b100, and the result SHALL still be computed with that operand as +0.
REQ-026 When ADD_SUB_INVZ_EN is not defined, the INVZ port SHALL be absent and behaviour is otherwise identical.

Verification
REQ-027 Add of two negatives: OP=0, A=111, B=111, in_valid=1 -> next cycle R=1110, SF=1, ZF=0, DZF=0, out_valid=1.
REQ-028 Subtract to zero: OP=1, A=011, B=011 -> R=0000, SF=0, ZF=1.
REQ-029 Mixed signs: OP=0, A=101, B=011 -> R=0010, SF=0; OP=1, A=010, B=111 -> R=0101.
REQ-030 Negative result: OP=1, A=000, B=001 -> R=1001, SF=1, ZF=0.
REQ-031 Exhaustive sweep: all 49 valid A/B pairs (no 100 encoding) under both OP values -> R matches signed-integer A+B or A-B, DZF=0 throughout.
REQ-032 Control: hold in_valid=0 -> outputs held and out_valid=0; assert rst_n=0 mid-stream -> reset values on the next edge; with ADD_SUB_INVZ_EN defined, A=100, B=010, OP=0 -> R=0010, INVZ=1.

Source files
------------

// File: rtl/add_sub.sv
// Registered 3-bit sign-magnitude adder/subtractor with SF/ZF/DZF flags and one-cycle latency.
// Define ADD_SUB_INVZ_EN to add the INVZ output, which flags negative-zero operands.
module add_sub (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       OP,
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic [3:0] R,
    output logic       SF,
    output logic       ZF,
    output logic       DZF,
    output logic       out_valid
`ifdef ADD_SUB_INVZ_EN
    ,
    output logic       INVZ
`endif
);

    logic       sa, sb;
    logic [1:0] ma, mb;
    logic [2:0] mag_d;
    logic       sign_d;
    logic [3:0] r_d, r_q;
    logic       vld_q;

    always_comb begin
        ma = A[1:0];
        mb = B[1:0];
        // A zero-magnitude operand drops its sign, so 3'b100 behaves as +0.
        sa = A[2] & (|ma);
        sb = (B[2] & (|mb)) ^ OP;
        if (sa == sb) begin
            mag_d  = {1'b0, ma} + {1'b0, mb};
            sign_d = sa;
        end else if (ma >= mb) begin
            mag_d  = {1'b0, ma - mb};
            sign_d = sa;
        end else begin
            mag_d  = {1'b0, mb - ma};
            sign_d = sb;
        end
        r_d = (mag_d == 3'd0) ? '0 : {sign_d, mag_d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                r_q <= r_d;
            end
        end
    end

`ifdef ADD_SUB_INVZ_EN
    logic invz_d, invz_q;

    always_comb begin
        invz_d = (A == 3'b100) | (B == 3'b100);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            invz_q <= 1'b0;
        end else if (in_valid) begin
            invz_q <= invz_d;
        end
    end

    assign INVZ = invz_q;
`endif

    assign R         = r_q;
    assign SF        = r_q[3];
    assign ZF        = (r_q == 4'b0000);
    assign DZF       = 1'b0;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_add_sub.sv
// Scoreboard testbench for add_sub: a signed-integer reference model fills the queue, and results are popped when out_valid rises.
// Checks INVZ as well when ADD_SUB_INVZ_EN is defined.
module tb_add_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       OP;
    logic [2:0] A;
    logic [2:0] B;
    logic [3:0] R;
    logic       SF;
    logic       ZF;
    logic       DZF;
    logic       out_valid;
`ifdef ADD_SUB_INVZ_EN
    logic       INVZ;
`endif

    add_sub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .OP        (OP),
        .A         (A),
        .B         (B),
        .R         (R),
        .SF        (SF),
        .ZF        (ZF),
        .DZF       (DZF),
        .out_valid (out_valid)
`ifdef ADD_SUB_INVZ_EN
        ,
        .INVZ      (INVZ)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic       invz;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       exp_vld;
    logic [3:0] last_r;
    logic       last_invz;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic op, input logic [2:0] a, input logic [2:0] b);
        exp_t e;
        int   va, vb, res;
        va = a[2] ? -int'(a[1:0]) : int'(a[1:0]);
        vb = b[2] ? -int'(b[1:0]) : int'(b[1:0]);
        res = op ? (va - vb) : (va + vb);
        if (res < 0) e.r = {1'b1, 3'(-res)};
        else         e.r = {1'b0, 3'(res)};
        e.invz = (a == 3'b100) || (b == 3'b100);
        return e;
    endfunction

    // Sample one time unit after the rising edge and compare against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        check("out_valid", 8'(out_valid), 8'(exp_vld));
        check("DZF", 8'(DZF), 8'h0);
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_depth", 8'(sb_q.size()), 8'h1);
            end else begin
                e = sb_q.pop_front();
                check("R", 8'(R), 8'(e.r));
                check("SF", 8'(SF), 8'(e.r[3]));
                check("ZF", 8'(ZF), 8'(e.r == 4'b0000));
`ifdef ADD_SUB_INVZ_EN
                check("INVZ", 8'(INVZ), 8'(e.invz));
`endif
            end
        end else begin
            check("hold_R", 8'(R), 8'(last_r));
            check("hold_ZF", 8'(ZF), 8'(last_r == 4'b0000));
`ifdef ADD_SUB_INVZ_EN
            check("hold_INVZ", 8'(INVZ), 8'(last_invz));
`endif
        end
    endtask

    task automatic drive(input logic rst, input logic vld, input logic op,
                         input logic [2:0] a, input logic [2:0] b);
        exp_t e;
        @(negedge clk);
        rst_n    = rst;
        in_valid = vld;
        OP       = op;
        A        = a;
        B        = b;
        exp_vld  = rst && vld;
        if (!rst) begin
            last_r    = 4'b0000;
            last_invz = 1'b0;
            sb_q.delete();
        end else if (vld) begin
            e = model(op, a, b);
            sb_q.push_back(e);
            last_r    = e.r;
            last_invz = e.invz;
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        OP        = 1'b0;
        A         = '0;
        B         = '0;
        exp_vld   = 1'b0;
        last_r    = 4'b0000;
        last_invz = 1'b0;

        // Reset with an operation presented: it must be discarded.
        drive(1'b0, 1'b1, 1'b0, 3'b011, 3'b011);
        check("rst_R", 8'(R), 8'h0);
        check("rst_ZF", 8'(ZF), 8'h1);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);

        // Directed cases.
        drive(1'b1, 1'b1, 1'b0, 3'b111, 3'b111);
        check("neg_add_R", 8'(R), 8'he);
        drive(1'b1, 1'b1, 1'b1, 3'b011, 3'b011);
        check("sub_zero_R", 8'(R), 8'h0);
        drive(1'b1, 1'b1, 1'b0, 3'b101, 3'b011);
        check("mixed1_R", 8'(R), 8'h2);
        drive(1'b1, 1'b1, 1'b1, 3'b010, 3'b111);
        check("mixed2_R", 8'(R), 8'h5);
        drive(1'b1, 1'b1, 1'b1, 3'b000, 3'b001);
        check("neg_res_R", 8'(R), 8'h9);

        // Hold: outputs keep the last result while in_valid is low.
        drive(1'b1, 1'b0, 1'b0, 3'b011, 3'b011);
        drive(1'b1, 1'b0, 1'b1, 3'b111, 3'b001);
        check("hold_last_R", 8'(R), 8'h9);

        // Exhaustive sweep of valid encodings, back to back, both operations.
        for (int op = 0; op < 2; op++) begin
            for (int ia = 0; ia < 8; ia++) begin
                for (int ib = 0; ib < 8; ib++) begin
                    if (ia != 4 && ib != 4) begin
                        drive(1'b1, 1'b1, 1'(op), 3'(ia), 3'(ib));
                    end
                end
            end
        end

        // Negative-zero operand behaves as +0.
        drive(1'b1, 1'b1, 1'b0, 3'b100, 3'b010);
        check("negzero_R", 8'(R), 8'h2);
        drive(1'b1, 1'b1, 1'b1, 3'b001, 3'b100);
        check("negzero_sub_R", 8'(R), 8'h1);

        // Random traffic, including 3'b100, with sparse bubbles.
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        // Mid-stream reset.
        drive(1'b1, 1'b1, 1'b0, 3'b011, 3'b010);
        drive(1'b0, 1'b1, 1'b0, 3'b011, 3'b011);
        check("mid_rst_R", 8'(R), 8'h0);
        check("mid_rst_SF", 8'(SF), 8'h0);
        check("mid_rst_ZF", 8'(ZF), 8'h1);
        drive(1'b1, 1'b1, 1'b1, 3'b110, 3'b001);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);

        check("sb_drained", 8'(sb_q.size()), 8'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
